alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Operand/opcode front end that sits directly upstream of the 4-bit ALU datapath and its result register.
- Buffers incoming {A,B,S} operations in a small FIFO and issues them one at a time, holding the ALU inputs stable for the ALU's result latency.
- Captures F/C_OUT and presents each result, tagged with its select code, on a valid/ready output.
- Gives software-style producers a decoupled, back-pressured interface to the combinational-plus-register ALU.

Parameters:
- DEPTH, 4, operation FIFO entries; power of 2, at least 2.
- LATENCY, 1, clock cycles from stable ALU inputs until ALU_F/ALU_COUT are valid; range 0..7.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  producer has an operation on IN_A/IN_B/IN_S.
- IN_READY  output  1  FIFO can accept; high when not full.
- IN_A  input  4  operand A.
- IN_B  input  4  operand B.
- IN_S  input  4  ALU select: S[0] arith/other, S[1] logic/compare, S[3:2] sub-op.
- ALU_A  output  4  registered operand A to the ALU.
- ALU_B  output  4  registered operand B to the ALU.
- ALU_S  output  4  registered select to the ALU.
- ALU_F  input  4  ALU result, valid LATENCY cycles after the ALU inputs change.
- ALU_COUT  input  1  arithmetic carry, same timing as ALU_F.
- RES_VALID  output  1  result holding registers are valid.
- RES_READY  input  1  consumer accepts the result.
- RES_F  output  4  captured ALU_F.
- RES_COUT  output  1  captured ALU_COUT; forced 0 when RES_S[0]=1 (non-arithmetic).
- RES_S  output  4  select code of the captured operation.
- BUSY  output  1  high when the FSM is not in IDLE or the FIFO is not empty.
- FIFO_COUNT  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (RST low, asynchronous)
  - FIFO empty; read and write pointers 0.
  - FSM in IDLE; issue counter 0.
  - ALU_A/ALU_B/ALU_S = 0; RES_F/RES_COUT/RES_S = 0; RES_VALID = 0.
  - IN_READY = 0 while RST is low, and 1 from the first edge after release.
  - Reset mid-operation discards every queued, in-flight and held result; nothing is replayed.
- FIFO
  - Push on IN_VALID && IN_READY.
  - IN_READY = !full, purely from registered occupancy; no bypass when full, even on a simultaneous pop.
  - Push and pop in the same cycle leave FIFO_COUNT unchanged.
  - Pointers wrap modulo DEPTH.
  - IN_VALID while IN_READY is low is ignored; producer data is not consumed.
- FSM, 3 states
  - IDLE: if the FIFO is not empty, pop the head into ALU_A/ALU_B/ALU_S, load cnt = LATENCY, and go to EXEC.
  - EXEC: ALU_* are held constant. If cnt == 0, capture ALU_F, ALU_COUT (masked) and ALU_S into RES_*, set RES_VALID = 1, go to DONE. Otherwise decrement cnt.
  - DONE: RES_VALID held high and RES_* stable until RES_READY.
    - RES_READY with FIFO not empty: clear RES_VALID, pop the next op, load cnt, go to EXEC (back-to-back).
    - RES_READY with FIFO empty: clear RES_VALID, go to IDLE.
- Timing
  - An op popped at edge t is driven on ALU_* from cycle t+1; result is captured at edge t+1+LATENCY.
  - Per-op occupancy is LATENCY+2 cycles, assuming RES_READY is high.
- Ordering
  - Results are delivered strictly in push order.
  - RES_* never changes while RES_VALID=1 and RES_READY=0.
- ALU_* hold the last issued op after completion; they are not zeroed.

Test Plan:
- Bench uses an ALU stub with LATENCY-cycle delay: S[0]=0 gives F=(A+B)[3:0], COUT=carry; S[0]=1 gives F=A&B.
- Single op, LATENCY=1: push A=9, B=8, S=0 at cycle 0 -> ALU_A=9 at cycle 2; RES_VALID at cycle 4 with RES_F=1, RES_COUT=1, RES_S=0.
- Fill: push 5 ops back-to-back with RES_READY=0, DEPTH=4 -> op1 issues and 4 are queued; IN_READY drops when FIFO_COUNT=4. The 6th push is held until RES_READY pulses.
- Back-pressure: RES_READY=0 for 10 cycles after RES_VALID -> RES_F/RES_S stable, no new issue. On RES_READY=1 the next op's ALU_A changes the following cycle.
- Logic op masking: A=4'hF, B=4'h3, S=4'b0001 -> RES_F=3, RES_COUT=0 even if the stub drives COUT=1.
- Order and wrap: stream 10 ops A=i, B=1, S=0 with random RES_READY -> RES_F = i+1 mod 16 in order; pointers wrap cleanly; FIFO_COUNT returns to 0 and BUSY=0 at the end.
- Reset mid-EXEC: assert RST with 2 ops queued -> outputs zero immediately. After release FIFO_COUNT=0, RES_VALID never rises, IN_READY=1 next cycle.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Front end for a 4-bit ALU that has a fixed result latency. Incoming
//   {A,B,S} operations are queued in a DEPTH-entry FIFO. They are issued to
//   the ALU one at a time, and ALU_A/B/S are held stable until the result
//   is captured. Each result is then presented on a valid/ready output,
//   tagged with the select code that produced it.
// Ports
//   CLK, RST                  clock, async active-low reset
//   IN_VALID/IN_READY         producer handshake; IN_A/IN_B/IN_S operation
//   ALU_A/ALU_B/ALU_S         registered operands/select driven to the ALU
//   ALU_F/ALU_COUT            ALU result, valid LATENCY cycles after issue
//   RES_VALID/RES_READY       consumer handshake; RES_F/RES_COUT/RES_S result
//   BUSY                      FSM not idle or FIFO not empty
//   FIFO_COUNT                current FIFO occupancy
module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [3:0]               IN_A,
    input  logic [3:0]               IN_B,
    input  logic [3:0]               IN_S,
    output logic [3:0]               ALU_A,
    output logic [3:0]               ALU_B,
    output logic [3:0]               ALU_S,
    input  logic [3:0]               ALU_F,
    input  logic                     ALU_COUT,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic [3:0]               RES_F,
    output logic                     RES_COUT,
    output logic [3:0]               RES_S,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q, count_d;
    logic            in_rdy_q;
    logic [11:0]     mem_q [DEPTH];
    logic [2:0]      cnt_q;
    logic [3:0]      alu_a_q, alu_b_q, alu_s_q;
    logic [3:0]      res_f_q, res_s_q;
    logic            res_c_q, res_v_q;
    logic            push, pop, empty;
    logic [11:0]     head;

    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];
    assign push  = IN_VALID && in_rdy_q;
    // Pops only happen on an FSM issue: from IDLE, or from DONE as the
    // current result is accepted (back-to-back issue).
    assign pop   = !empty && ((state_q == IDLE) || (state_q == DONE && RES_READY));

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    // FIFO storage carries no reset; occupancy/pointers define validity.
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wptr_q] <= {IN_A, IN_B, IN_S};
    end

    // Ready is registered from next occupancy. It therefore stays low
    // during reset, and a pop does not let a push into a full FIFO.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q  <= count_d;
            in_rdy_q <= (count_d != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_s_q <= '0;
            res_f_q <= '0;
            res_c_q <= 1'b0;
            res_s_q <= '0;
            res_v_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {alu_a_q, alu_b_q, alu_s_q} <= head;
                        cnt_q   <= 3'(LATENCY);
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        res_f_q <= ALU_F;
                        // Carry is meaningless for non-arithmetic ops.
                        res_c_q <= ALU_COUT & ~alu_s_q[0];
                        res_s_q <= alu_s_q;
                        res_v_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (RES_READY) begin
                        res_v_q <= 1'b0;
                        if (pop) begin
                            {alu_a_q, alu_b_q, alu_s_q} <= head;
                            cnt_q   <= 3'(LATENCY);
                            state_q <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY   = in_rdy_q;
    assign ALU_A      = alu_a_q;
    assign ALU_B      = alu_b_q;
    assign ALU_S      = alu_s_q;
    assign RES_VALID  = res_v_q;
    assign RES_F      = res_f_q;
    assign RES_COUT   = res_c_q;
    assign RES_S      = res_s_q;
    assign BUSY       = (state_q != IDLE) || !empty;
    assign FIFO_COUNT = count_q;

endmodule
